// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the internal 32-bit peripheral bus responder:
//   - bus widths and the number of words returned in a read phase
//   - responder state enumeration
//   - bit positions of the status word and a helper that assembles it
// -----------------------------------------------------------------------------
package bus_pkg;

   localparam int BUS_ADDR_W     = 8;
   localparam int BUS_DATA_W     = 32;
   localparam int NUM_READ_WORDS = 2;

   // Word indices within the read phase
   localparam int WORD_REG    = 0;
   localparam int WORD_STATUS = 1;

   // Status word layout
   localparam int ST_HIT      = 0;
   localparam int ST_WR_DONE  = 1;
   localparam int ST_RO_ERR   = 2;
   localparam int ST_TIMEOUT  = 3;
   localparam int ST_ADDR_LSB = 24;
   localparam int ST_ADDR_MSB = 31;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_W_ACK  = 3'd1,
      S_W_REL  = 3'd2,
      S_R_WAIT = 3'd3,
      S_R_LOAD = 3'd4,
      S_R_ACK  = 3'd5,
      S_R_REL  = 3'd6
   } resp_state_e;

   function automatic logic [BUS_DATA_W-1:0] make_status(
      input logic [BUS_ADDR_W-1:0] addr,
      input logic                  timeout,
      input logic                  ro_err,
      input logic                  wr_done
   );
      logic [BUS_DATA_W-1:0] s;
      s                          = '0;
      s[ST_ADDR_MSB:ST_ADDR_LSB] = addr;
      s[ST_TIMEOUT]              = timeout;
      s[ST_RO_ERR]               = ro_err;
      s[ST_WR_DONE]              = wr_done;
      s[ST_HIT]                  = 1'b1;
      return s;
   endfunction

endpackage

// File: rtl/bus_subsystem_responder_if.sv
// -----------------------------------------------------------------------------
// bus_subsystem_responder_if
// Handshake/data signals of the internal peripheral bus.
//   master modport : uP-side bus master (drives address, write word, request)
//   slave  modport : subsystem responder (drives acknowledge and read word)
// bus_handshake_2 and bus_data_out are OR-combined at the top level, so a
// responder that is not selected keeps both at zero.
// -----------------------------------------------------------------------------
interface bus_subsystem_responder_if;
   import bus_pkg::*;

   logic [BUS_ADDR_W-1:0] register_address;
   logic                  register_address_valid;
   logic                  bus_write;
   logic [BUS_DATA_W-1:0] bus_data_in;
   logic                  bus_handshake_1;
   logic                  bus_handshake_2;
   logic [BUS_DATA_W-1:0] bus_data_out;
   logic                  bus_data_out_en;

   modport master (
      output register_address, register_address_valid, bus_write,
             bus_data_in, bus_handshake_1,
      input  bus_handshake_2, bus_data_out, bus_data_out_en
   );

   modport slave (
      input  register_address, register_address_valid, bus_write,
             bus_data_in, bus_handshake_1,
      output bus_handshake_2, bus_data_out, bus_data_out_en
   );

endinterface

// File: rtl/bus_reg_file.sv
// -----------------------------------------------------------------------------
// bus_reg_file
// NUM_REGS x 32-bit register bank behind the bus responder.
//   clk, reset   : clock, asynchronous active-low reset (bank clears to 0)
//   we_i         : write request for register widx_i (ignored if read-only)
//   widx_i       : write index, wdata_i : write word
//   wr_ro_o      : register selected by widx_i is read-only
//   ridx_i       : read index, rdata_o : readback (reg_in slice if read-only)
//   reg_out_o    : bank contents to the subsystem
//   reg_in_i     : subsystem values returned for read-only registers
//   strobe_o     : one-cycle pulse per register written, aligned with the
//                  first cycle reg_out_o shows the new value
// -----------------------------------------------------------------------------
module bus_reg_file
   import bus_pkg::*;
#(
   parameter int                  NUM_REGS       = 4,
   parameter logic [NUM_REGS-1:0] READ_ONLY_MASK = '0,
   parameter int                  IDX_W          = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           we_i,
   input  logic [IDX_W-1:0]               widx_i,
   input  logic [BUS_DATA_W-1:0]          wdata_i,
   output logic                           wr_ro_o,
   input  logic [IDX_W-1:0]               ridx_i,
   output logic [BUS_DATA_W-1:0]          rdata_o,
   output logic [NUM_REGS*BUS_DATA_W-1:0] reg_out_o,
   input  logic [NUM_REGS*BUS_DATA_W-1:0] reg_in_i,
   output logic [NUM_REGS-1:0]            strobe_o
);

   logic [BUS_DATA_W-1:0] regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]   strobe_q;
   logic [NUM_REGS-1:0]   wsel;

   // Compare against each legal index so a non-power-of-two bank never
   // indexes past its end.
   always_comb begin
      wsel    = '0;
      wr_ro_o = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (widx_i == IDX_W'(i)) begin
            wsel[i] = 1'b1;
            wr_ro_o = READ_ONLY_MASK[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         strobe_q <= '0;
      end else begin
         strobe_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (we_i && wsel[i] && !READ_ONLY_MASK[i]) begin
               regs_q[i]   <= wdata_i;
               strobe_q[i] <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ridx_i == IDX_W'(i)) begin
            rdata_o = READ_ONLY_MASK[i] ? reg_in_i[i*BUS_DATA_W +: BUS_DATA_W]
                                        : regs_q[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_out_o[i*BUS_DATA_W +: BUS_DATA_W] = regs_q[i];
      end
   end

   assign strobe_o = strobe_q;

endmodule

// File: rtl/bus_subsystem_responder.sv
// -----------------------------------------------------------------------------
// bus_subsystem_responder
// Slave end of the internal 32-bit bus, one per peripheral subsystem.
// A transaction is a write phase (one handshake) followed by a read phase
// returning two words: the register value and a status word.
//   clk, reset        : clock, asynchronous active-low reset
//   bus_if (slave)    : address/valid/write/data/request in,
//                       acknowledge/read word/read-enable out
//   reg_out           : register bank contents to the subsystem
//   reg_in            : values returned for read-only registers
//   reg_write_strobe  : one-cycle pulse per register written
// Optional build macro BUS_RESPONDER_TIMEOUT_EN adds a watchdog that abandons
// a stalled transaction after TIMEOUT_CYCLES cycles in a wait state and
// reports it in status bit 3.
// -----------------------------------------------------------------------------
module bus_subsystem_responder
   import bus_pkg::*;
#(
   parameter logic [BUS_ADDR_W-1:0] BASE_ADDR      = 8'h00,
   parameter int                    NUM_REGS       = 4,
   parameter logic [NUM_REGS-1:0]   READ_ONLY_MASK = '0,
   parameter int                    TIMEOUT_CYCLES = 1024
) (
   input  logic                            clk,
   input  logic                            reset,
   bus_subsystem_responder_if.slave        bus_if,
   output logic [NUM_REGS*BUS_DATA_W-1:0]  reg_out,
   input  logic [NUM_REGS*BUS_DATA_W-1:0]  reg_in,
   output logic [NUM_REGS-1:0]             reg_write_strobe
);

   localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int WIDX_W = (NUM_READ_WORDS > 1) ? $clog2(NUM_READ_WORDS) : 1;
   localparam logic [WIDX_W-1:0] LAST_WORD   = WIDX_W'(NUM_READ_WORDS - 1);
   localparam logic [WIDX_W-1:0] STATUS_WORD = WIDX_W'(WORD_STATUS);

   resp_state_e           state_q, state_d;
   logic [BUS_ADDR_W-1:0] addr_q;
   logic [IDX_W-1:0]      idx_q;
   logic [WIDX_W-1:0]     widx_q;
   logic                  ro_err_q;
   logic                  wr_done_q;
   logic [BUS_DATA_W-1:0] dout_q;
   logic                  dout_en_q;
   logic                  dout_en_d;

   logic [BUS_ADDR_W-1:0] addr_diff;
   logic                  hit;
   logic [IDX_W-1:0]      idx_live;
   logic                  enter_w_ack;
   logic                  load_word;
   logic                  wr_ro;
   logic [BUS_DATA_W-1:0] reg_word;
   logic [BUS_DATA_W-1:0] read_word;
   logic                  tmo_fire;
   logic                  tmo_flag;

   // Unsigned 8-bit subtract: addresses below BASE_ADDR wrap to large values
   // and fall out of range together with those above the bank.
   assign addr_diff = bus_if.register_address - BASE_ADDR;
   assign hit       = bus_if.register_address_valid &&
                      (addr_diff < BUS_ADDR_W'(NUM_REGS));
   assign idx_live  = addr_diff[IDX_W-1:0];

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (hit && bus_if.bus_handshake_1)  state_d = S_W_ACK;
         S_W_ACK:  if (!bus_if.bus_handshake_1)        state_d = S_W_REL;
         S_W_REL:                                      state_d = S_R_WAIT;
         S_R_WAIT: if (bus_if.bus_handshake_1)         state_d = S_R_LOAD;
         S_R_LOAD:                                     state_d = S_R_ACK;
         S_R_ACK:  if (!bus_if.bus_handshake_1)        state_d = S_R_REL;
         S_R_REL:  state_d = (widx_q == LAST_WORD) ? S_IDLE : S_R_WAIT;
         default:                                      state_d = S_IDLE;
      endcase
      // Master abandoning the transaction or the watchdog firing both end it
      if (state_q != S_IDLE && !bus_if.register_address_valid) begin
         state_d = S_IDLE;
      end
      if (tmo_fire) begin
         state_d = S_IDLE;
      end
   end

   assign enter_w_ack = (state_q == S_IDLE) && (state_d == S_W_ACK);
   // Read word is registered on the way into S_R_LOAD so it is stable for a
   // full cycle before the acknowledge rises.
   assign load_word   = (state_q == S_R_WAIT) && (state_d == S_R_LOAD);
   assign dout_en_d   = (state_d == S_R_LOAD) || (state_d == S_R_ACK);

   assign read_word = (widx_q == STATUS_WORD)
                      ? make_status(addr_q, tmo_flag, ro_err_q, wr_done_q)
                      : reg_word;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         idx_q     <= '0;
         widx_q    <= '0;
         ro_err_q  <= 1'b0;
         wr_done_q <= 1'b0;
         dout_q    <= '0;
         dout_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         // Address is captured once; later changes in the transaction are ignored
         if (enter_w_ack) begin
            addr_q    <= bus_if.register_address;
            idx_q     <= idx_live;
            ro_err_q  <= bus_if.bus_write && wr_ro;
            wr_done_q <= bus_if.bus_write && !wr_ro;
         end
         if (state_q == S_W_REL) begin
            widx_q <= '0;
         end else if (state_q == S_R_REL) begin
            widx_q <= widx_q + 1'b1;
         end
         if (load_word) begin
            dout_q <= read_word;
         end else if (!dout_en_d) begin
            dout_q <= '0;
         end
         dout_en_q <= dout_en_d;
      end
   end

   // The write commits on the same edge that enters S_W_ACK, so the strobe
   // and the updated reg_out appear together in the first acknowledge cycle.
   bus_reg_file #(
      .NUM_REGS       (NUM_REGS),
      .READ_ONLY_MASK (READ_ONLY_MASK),
      .IDX_W          (IDX_W)
   ) u_reg_file (
      .clk       (clk),
      .reset     (reset),
      .we_i      (enter_w_ack && bus_if.bus_write),
      .widx_i    (idx_live),
      .wdata_i   (bus_if.bus_data_in),
      .wr_ro_o   (wr_ro),
      .ridx_i    (idx_q),
      .rdata_o   (reg_word),
      .reg_out_o (reg_out),
      .reg_in_i  (reg_in),
      .strobe_o  (reg_write_strobe)
   );

`ifdef BUS_RESPONDER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q;
   logic             waiting;
   logic             stay;

   assign waiting = (state_q == S_W_ACK) || (state_q == S_R_WAIT) ||
                    (state_q == S_R_ACK);
   // A wait state that would not advance this cycle
   assign stay = ((state_q == S_W_ACK)  &&  bus_if.bus_handshake_1) ||
                 ((state_q == S_R_WAIT) && !bus_if.bus_handshake_1) ||
                 ((state_q == S_R_ACK)  &&  bus_if.bus_handshake_1);
   // Counter holds the wait cycles left including the current one
   assign tmo_fire = stay && bus_if.register_address_valid &&
                     (cnt_q == CNT_W'(1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = CNT_W'(TIMEOUT_CYCLES);
      end else if (waiting) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         // Sticky until the status word carrying it has been loaded
         if (tmo_fire) begin
            tmo_q <= 1'b1;
         end else if (load_word && (widx_q == STATUS_WORD)) begin
            tmo_q <= 1'b0;
         end
      end
   end

   assign tmo_flag = tmo_q;
`else
   assign tmo_fire = 1'b0;
   assign tmo_flag = 1'b0;
`endif

   assign bus_if.bus_handshake_2 = (state_q == S_W_ACK) || (state_q == S_R_ACK);
   assign bus_if.bus_data_out    = dout_q;
   assign bus_if.bus_data_out_en = dout_en_q;

endmodule
